// File: rtl/brq_pkg.sv
// Shared types and constants for the branch resolve queue.
// The entry index width is fixed here; the top-level INDEX_WIDTH should match it.
// PC step is the fall-through distance used when a taken prediction was wrong.
package brq_pkg;

  localparam int BRQ_INDEX_WIDTH = 8;
  localparam logic [31:0] BRQ_PC_STEP = 32'd4;

  typedef struct packed {
    logic [31:0]                pc;
    logic [BRQ_INDEX_WIDTH-1:0] index;
    logic                       pred;
    logic [31:0]                target;
  } brq_entry_t;

endpackage

// File: rtl/brq_fifo.sv
// Circular FIFO of brq_entry_t with a synchronous flush that empties it in one cycle.
// Latency: a pushed entry is visible at head_data the cycle after the push.
// Backpressure: pushes while full and pops while empty are ignored; flush beats push and pop.
module brq_fifo
  import brq_pkg::*;
#(
  parameter int DEPTH_LOG2 = 2
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  flush,
  input  logic                  push,
  input  brq_entry_t            push_data,
  input  logic                  pop,
  output brq_entry_t            head_data,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  full,
  output logic                  empty
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  brq_entry_t            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] head;
  logic [DEPTH_LOG2-1:0] tail;
  logic                  do_push;
  logic                  do_pop;

  assign full      = (count == (DEPTH_LOG2 + 1)'(DEPTH));
  assign empty     = (count == '0);
  assign do_push   = push & ~full & ~flush;
  assign do_pop    = pop & ~empty & ~flush;
  assign head_data = mem[head];

  // Entry storage: written at the tail, never reset (occupancy guards every read).
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[tail] <= push_data;
    end
  end

  // Pointers and occupancy; flush returns the queue to its reset state.
  always_ff @(posedge clk) begin
    if (!rstn || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (do_push) tail <= tail + DEPTH_LOG2'(1);
      if (do_pop)  head <= head + DEPTH_LOG2'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (DEPTH_LOG2 + 1)'(1);
        2'b01:   count <= count - (DEPTH_LOG2 + 1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/branch_resolve_queue.sv
// Holds predicted branches in order, checks outcomes from execute, drives predictor updates and flushes.
// Latency: update/mispredict pulse 1 cycle after resolve; resolves are spaced so upd_valid is never back-to-back.
// Backpressure: push_ready = ~full (no bypass); res_ready = ~empty & ~upd_valid. Stats counters built only with BRQ_STATS_EN.
module branch_resolve_queue
  import brq_pkg::*;
#(
  parameter int DEPTH_LOG2  = 2,
  parameter int INDEX_WIDTH = BRQ_INDEX_WIDTH
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   push_valid,
  output logic                   push_ready,
  input  logic [31:0]            push_pc,
  input  logic [INDEX_WIDTH-1:0] push_index,
  input  logic                   push_pred,
  input  logic [31:0]            push_target,
  input  logic                   res_valid,
  output logic                   res_ready,
  input  logic                   res_taken,
  output logic                   upd_valid,
  output logic [31:0]            upd_pc,
  output logic [INDEX_WIDTH-1:0] upd_index,
  output logic                   upd_taken,
  output logic                   mispredict,
  output logic [31:0]            redirect_pc,
  output logic [DEPTH_LOG2:0]    count,
  output logic [31:0]            stat_branches,
  output logic [31:0]            stat_mispredicts
);

  brq_entry_t push_entry;
  brq_entry_t head_entry;
  logic       full;
  logic       empty;
  logic       push_fire;
  logic       res_fire;
  logic       mis_now;

  // Pack the incoming prediction into a queue entry.
  always_comb begin
    push_entry        = '0;
    push_entry.pc     = push_pc;
    push_entry.index  = BRQ_INDEX_WIDTH'(push_index);
    push_entry.pred   = push_pred;
    push_entry.target = push_target;
  end

  assign push_ready = ~full;
  assign res_ready  = ~empty & ~upd_valid;
  assign push_fire  = push_valid & push_ready;
  assign res_fire   = res_valid & res_ready;
  // A wrong prediction flushes everything younger, including a push arriving this cycle.
  assign mis_now    = res_fire & (res_taken != head_entry.pred);

  brq_fifo #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .flush     (mis_now),
    .push      (push_fire & ~mis_now),
    .push_data (push_entry),
    .pop       (res_fire),
    .head_data (head_entry),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  // Register the predictor update and flush for one cycle after each resolve.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      upd_valid   <= 1'b0;
      upd_pc      <= '0;
      upd_index   <= '0;
      upd_taken   <= 1'b0;
      mispredict  <= 1'b0;
      redirect_pc <= '0;
    end else begin
      upd_valid  <= res_fire;
      mispredict <= mis_now;
      if (res_fire) begin
        upd_pc    <= head_entry.pc;
        upd_index <= INDEX_WIDTH'(head_entry.index);
        upd_taken <= res_taken;
      end
      if (mis_now) begin
        redirect_pc <= res_taken ? head_entry.target : head_entry.pc + BRQ_PC_STEP;
      end
    end
  end

`ifdef BRQ_STATS_EN
  // Free-running resolve and mispredict counters, wrapping at 2^32.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else begin
      if (res_fire) stat_branches    <= stat_branches + 32'd1;
      if (mis_now)  stat_mispredicts <= stat_mispredicts + 32'd1;
    end
  end
`else
  assign stat_branches    = '0;
  assign stat_mispredicts = '0;
`endif

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Directed bench for branch_resolve_queue (DEPTH_LOG2=2, INDEX_WIDTH=8).
// Inputs change 1ns after the rising edge; outputs are sampled there too.
// Stats expectations follow whether BRQ_STATS_EN is defined for the build.
module tb_branch_resolve_queue;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        push_valid = 1'b0;
  logic        push_ready;
  logic [31:0] push_pc = '0;
  logic [7:0]  push_index = '0;
  logic        push_pred = 1'b0;
  logic [31:0] push_target = '0;
  logic        res_valid = 1'b0;
  logic        res_ready;
  logic        res_taken = 1'b0;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic [7:0]  upd_index;
  logic        upd_taken;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic [2:0]  count;
  logic [31:0] stat_branches;
  logic [31:0] stat_mispredicts;

  int checks = 0;
  int errors = 0;

  branch_resolve_queue #(.DEPTH_LOG2(2), .INDEX_WIDTH(8)) dut (
    .clk(clk), .rstn(rstn),
    .push_valid(push_valid), .push_ready(push_ready), .push_pc(push_pc),
    .push_index(push_index), .push_pred(push_pred), .push_target(push_target),
    .res_valid(res_valid), .res_ready(res_ready), .res_taken(res_taken),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_index(upd_index), .upd_taken(upd_taken),
    .mispredict(mispredict), .redirect_pc(redirect_pc), .count(count),
    .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [31:0] pc, input logic [7:0] idx,
                          input logic pred, input logic [31:0] tgt);
    push_valid = 1'b1; push_pc = pc; push_index = idx; push_pred = pred; push_target = tgt;
    tick();
    push_valid = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    tick(); tick(); tick();
    rstn = 1'b1;
    #1;
    checks++; if (upd_valid !== 1'b0) begin errors++; $display("FAIL reset_upd_valid: got %b want 0", upd_valid); end
    checks++; if (mispredict !== 1'b0) begin errors++; $display("FAIL reset_mispredict: got %b want 0", mispredict); end
    checks++; if (redirect_pc !== 32'h0) begin errors++; $display("FAIL reset_redirect: got %h want 0", redirect_pc); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
    checks++; if (push_ready !== 1'b1) begin errors++; $display("FAIL reset_push_ready: got %b want 1", push_ready); end
    checks++; if (res_ready !== 1'b0) begin errors++; $display("FAIL reset_res_ready: got %b want 0", res_ready); end
    checks++; if (upd_pc !== 32'h0) begin errors++; $display("FAIL reset_upd_pc: got %h want 0", upd_pc); end
    checks++; if (stat_branches !== 32'h0 || stat_mispredicts !== 32'h0)
      begin errors++; $display("FAIL reset_stats: got %0d/%0d want 0/0", stat_branches, stat_mispredicts); end
  endtask

  task automatic test_correct_predict();
    push_one(32'h100, 8'h10, 1'b1, 32'h200);
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL cp_count_after_push: got %0d want 1", count); end
    res_valid = 1'b1; res_taken = 1'b1;
    #1;
    checks++; if (res_ready !== 1'b1) begin errors++; $display("FAIL cp_res_ready: got %b want 1", res_ready); end
    tick();
    res_valid = 1'b0;
    checks++; if (upd_valid !== 1'b1) begin errors++; $display("FAIL cp_upd_valid: got %b want 1", upd_valid); end
    checks++; if (upd_pc !== 32'h100) begin errors++; $display("FAIL cp_upd_pc: got %h want 100", upd_pc); end
    checks++; if (upd_index !== 8'h10) begin errors++; $display("FAIL cp_upd_index: got %h want 10", upd_index); end
    checks++; if (upd_taken !== 1'b1) begin errors++; $display("FAIL cp_upd_taken: got %b want 1", upd_taken); end
    checks++; if (mispredict !== 1'b0) begin errors++; $display("FAIL cp_mispredict: got %b want 0", mispredict); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL cp_count: got %0d want 0", count); end
    tick();
    checks++; if (upd_valid !== 1'b0) begin errors++; $display("FAIL cp_upd_pulse: got %b want 0", upd_valid); end
  endtask

  task automatic test_redirect();
    logic [31:0] pcs   [3] = '{32'h104, 32'h1FC, 32'hFFFF_FFFC};
    logic        preds [3] = '{1'b1, 1'b0, 1'b1};
    logic [31:0] tgts  [3] = '{32'h300, 32'h2000, 32'h40};
    logic [31:0] exp   [3] = '{32'h108, 32'h2000, 32'h0};
    for (int i = 0; i < 3; i++) begin
      push_one(pcs[i], 8'h22, preds[i], tgts[i]);
      res_valid = 1'b1; res_taken = ~preds[i];
      tick();
      res_valid = 1'b0;
      checks++; if (mispredict !== 1'b1) begin errors++; $display("FAIL rd_mispredict[%0d]: got %b want 1", i, mispredict); end
      checks++; if (redirect_pc !== exp[i]) begin errors++; $display("FAIL rd_redirect_pc[%0d]: got %h want %h", i, redirect_pc, exp[i]); end
      checks++; if (upd_valid !== 1'b1 || upd_taken !== ~preds[i])
        begin errors++; $display("FAIL rd_upd[%0d]: got valid=%b taken=%b want 1/%b", i, upd_valid, upd_taken, ~preds[i]); end
      tick();
      checks++; if (mispredict !== 1'b0) begin errors++; $display("FAIL rd_mispredict_pulse[%0d]: got %b want 0", i, mispredict); end
    end
  endtask

  task automatic test_full();
    for (int i = 0; i < 4; i++) push_one(32'h400 + 32'(16 * i), 8'(i), 1'b0, 32'h0);
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL full_count: got %0d want 4", count); end
    checks++; if (push_ready !== 1'b0) begin errors++; $display("FAIL full_push_ready: got %b want 0", push_ready); end
    push_one(32'h500, 8'h55, 1'b0, 32'h0);
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL full_fifth_push: got count %0d want 4", count); end
    res_valid = 1'b1; res_taken = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checks++; if (res_ready !== (i % 2 == 0))
        begin errors++; $display("FAIL full_res_ready[%0d]: got %b want %b", i, res_ready, (i % 2 == 0)); end
      tick();
      checks++; if (upd_valid !== (i % 2 == 0))
        begin errors++; $display("FAIL full_upd_valid[%0d]: got %b want %b", i, upd_valid, (i % 2 == 0)); end
      if (i % 2 == 0) begin
        checks++; if (upd_pc !== 32'h400 + 32'(16 * (i / 2)))
          begin errors++; $display("FAIL full_upd_pc[%0d]: got %h want %h", i, upd_pc, 32'h400 + 32'(16 * (i / 2))); end
      end
    end
    res_valid = 1'b0;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL full_drain_count: got %0d want 0", count); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) push_one(32'h900 + 32'(16 * i), 8'(i), 1'b0, 32'h0);
    res_valid = 1'b1; res_taken = 1'b0;
    push_valid = 1'b1; push_pc = 32'h990; push_pred = 1'b0;
    #1;
    checks++; if (push_ready !== 1'b0) begin errors++; $display("FAIL b2b_full_push_ready: got %b want 0", push_ready); end
    tick();
    push_valid = 1'b0; res_valid = 1'b0;
    checks++; if (count !== 3'd3) begin errors++; $display("FAIL b2b_no_bypass_count: got %0d want 3", count); end
    checks++; if (upd_pc !== 32'h900) begin errors++; $display("FAIL b2b_first_pc: got %h want 900", upd_pc); end
    tick();
    res_valid = 1'b1; res_taken = 1'b0;
    push_valid = 1'b1; push_pc = 32'h940; push_pred = 1'b0;
    tick();
    push_valid = 1'b0; res_valid = 1'b0;
    checks++; if (count !== 3'd3) begin errors++; $display("FAIL b2b_push_pop_count: got %0d want 3", count); end
    checks++; if (upd_pc !== 32'h910 || mispredict !== 1'b0)
      begin errors++; $display("FAIL b2b_second_upd: got pc=%h mis=%b want 910/0", upd_pc, mispredict); end
    tick();
    res_valid = 1'b1;
    for (int j = 0; j < 6; j++) begin
      tick();
      if (j % 2 == 0) begin
        checks++; if (upd_valid !== 1'b1 || upd_pc !== 32'h920 + 32'(16 * (j / 2)))
          begin errors++; $display("FAIL b2b_drain[%0d]: got v=%b pc=%h want 1/%h", j, upd_valid, upd_pc, 32'h920 + 32'(16 * (j / 2))); end
      end
    end
    res_valid = 1'b0;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL b2b_drain_count: got %0d want 0", count); end
  endtask

  task automatic test_flush_with_push();
    int n_upd;
    push_one(32'h600, 8'h60, 1'b1, 32'h700);
    push_one(32'h610, 8'h61, 1'b1, 32'h710);
    push_one(32'h620, 8'h62, 1'b1, 32'h720);
    res_valid = 1'b1; res_taken = 1'b0;
    push_valid = 1'b1; push_pc = 32'h630; push_pred = 1'b1; push_target = 32'h730;
    #1;
    checks++; if (push_ready !== 1'b1) begin errors++; $display("FAIL fl_push_ready: got %b want 1", push_ready); end
    tick();
    push_valid = 1'b0;
    n_upd = int'(upd_valid);
    checks++; if (mispredict !== 1'b1 || redirect_pc !== 32'h604)
      begin errors++; $display("FAIL fl_redirect: got mis=%b pc=%h want 1/604", mispredict, redirect_pc); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL fl_count: got %0d want 0", count); end
    for (int k = 0; k < 4; k++) begin
      tick();
      n_upd += int'(upd_valid);
    end
    res_valid = 1'b0;
    checks++; if (n_upd != 1) begin errors++; $display("FAIL fl_upd_pulses: got %0d want 1", n_upd); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL fl_count_after: got %0d want 0", count); end
  endtask

  task automatic test_reset_mid();
    push_one(32'h800, 8'h80, 1'b0, 32'h0);
    push_one(32'h810, 8'h81, 1'b0, 32'h0);
    res_valid = 1'b1; res_taken = 1'b0;
    tick();
    res_valid = 1'b0;
    checks++; if (upd_valid !== 1'b1 || count !== 3'd1)
      begin errors++; $display("FAIL rm_pre: got v=%b count=%0d want 1/1", upd_valid, count); end
    rstn = 1'b0;
    tick();
    checks++; if (upd_valid !== 1'b0 || count !== 3'd0)
      begin errors++; $display("FAIL rm_after_reset: got v=%b count=%0d want 0/0", upd_valid, count); end
    checks++; if (redirect_pc !== 32'h0) begin errors++; $display("FAIL rm_redirect: got %h want 0", redirect_pc); end
    rstn = 1'b1;
    push_one(32'h820, 8'h82, 1'b1, 32'h880);
    res_valid = 1'b1; res_taken = 1'b0; rstn = 1'b0;
    tick();
    res_valid = 1'b0; rstn = 1'b1;
    checks++; if (upd_valid !== 1'b0 || mispredict !== 1'b0 || redirect_pc !== 32'h0)
      begin errors++; $display("FAIL rm_pending: got v=%b mis=%b pc=%h want 0/0/0", upd_valid, mispredict, redirect_pc); end
  endtask

  task automatic test_stats();
    int mis_seen = 0;
    logic [31:0] exp_b, exp_m;
    rstn = 1'b0; tick(); rstn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      push_one(32'h1000 + 32'(8 * i), 8'(i), 1'b0, 32'h0);
      res_valid = 1'b1; res_taken = (i == 2 || i == 5 || i == 8);
      tick();
      res_valid = 1'b0;
      mis_seen += int'(mispredict);
      tick();
    end
`ifdef BRQ_STATS_EN
    exp_b = 32'd10; exp_m = 32'd3;
`else
    exp_b = 32'd0;  exp_m = 32'd0;
`endif
    checks++; if (mis_seen != 3) begin errors++; $display("FAIL st_mis_pulses: got %0d want 3", mis_seen); end
    checks++; if (stat_branches !== exp_b) begin errors++; $display("FAIL st_branches: got %0d want %0d", stat_branches, exp_b); end
    checks++; if (stat_mispredicts !== exp_m) begin errors++; $display("FAIL st_mispredicts: got %0d want %0d", stat_mispredicts, exp_m); end
  endtask

  initial begin
    test_reset();
    test_correct_predict();
    test_redirect();
    test_full();
    test_back_to_back();
    test_flush_with_push();
    test_reset_mid();
    test_stats();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
